stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_ctrl_if.sv | 29 ++
 rtl/stopwatch_ctrl.sv | 176 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button pulses in, counter control / set-mode load bus out.
// master = stopwatch_ctrl, slave = button conditioning + digit counter side.
interface stopwatch_ctrl_if;
    logic       btn_start;
    logic       btn_lap;
    logic       btn_mode;
    logic       btn_inc;
    logic       count_en;
    logic       clear;
    logic       load;
    logic [2:0] load_sel;
    logic [3:0] set_tens;
    logic [3:0] set_ones;
    logic       lap_hold;
    logic       running;
    logic [2:0] state;

    modport master (
        input  btn_start, btn_lap, btn_mode, btn_inc,
        output count_en, clear, load, load_sel, set_tens, set_ones,
               lap_hold, running, state
    );

    modport slave (
        output btn_start, btn_lap, btn_mode, btn_inc,
        input  count_en, clear, load, load_sel, set_tens, set_ones,
               lap_hold, running, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear sequencer, count-tick prescaler and
// set-mode load driver for the stopwatch digit counters.
// Optional feature macro: STOPWATCH_LAP_EN (lap_hold toggle while running).
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic              clk,
    input  logic              reset,
    stopwatch_ctrl_if.master  bus
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        PAUSE    = 3'd2,
        SET_HOUR = 3'd3,
        SET_MIN  = 3'd4,
        SET_SEC  = 3'd5
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             count_en_q;
    logic             clear_q;
    logic             load_q;
    logic [2:0]       load_sel_q;
    logic [3:0]       tens_q;
    logic [3:0]       ones_q;
    logic             lap_hold_q;
    logic             running_q;

    logic mode_p, start_p, lap_p, inc_p;
    logic [3:0] base_tens, base_ones, inc_tens, inc_ones;
    logic [3:0] max_tens, max_ones;
    logic [2:0] field_sel;
    state_t     field_next;

    // Resolve same-cycle buttons: mode > start > lap > inc.
    assign mode_p  = bus.btn_mode;
    assign start_p = bus.btn_start & ~bus.btn_mode;
    assign lap_p   = bus.btn_lap & ~bus.btn_mode & ~bus.btn_start;
    assign inc_p   = bus.btn_inc & ~bus.btn_mode & ~bus.btn_start & ~bus.btn_lap;

    // BCD increment of the field being set; a field just entered (load cycle) restarts from 00.
    always_comb begin
        base_tens  = load_q ? 4'd0 : tens_q;
        base_ones  = load_q ? 4'd0 : ones_q;
        max_tens   = (state_q == SET_HOUR) ? 4'd2 : 4'd5;
        max_ones   = (state_q == SET_HOUR) ? 4'd3 : 4'd9;
        inc_tens   = base_tens;
        inc_ones   = base_ones + 4'd1;
        if (base_tens == max_tens && base_ones == max_ones) begin
            inc_tens = 4'd0;
            inc_ones = 4'd0;
        end else if (base_ones == 4'd9) begin
            inc_tens = base_tens + 4'd1;
            inc_ones = 4'd0;
        end
        field_sel  = 3'b000;
        field_next = IDLE;
        case (state_q)
            SET_HOUR: begin field_sel = 3'b100; field_next = SET_MIN; end
            SET_MIN:  begin field_sel = 3'b010; field_next = SET_SEC; end
            SET_SEC:  begin field_sel = 3'b001; field_next = IDLE;    end
            default:  ;
        endcase
    end

    // Sequencer FSM with prescaler and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            count_en_q <= 1'b0;
            clear_q    <= 1'b0;
            load_q     <= 1'b0;
            load_sel_q <= 3'b000;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            lap_hold_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            count_en_q <= 1'b0;
            clear_q    <= 1'b0;
            load_q     <= 1'b0;
            load_sel_q <= 3'b000;
            case (state_q)
                IDLE: begin
                    cnt_q      <= '0;
                    tens_q     <= 4'd0;
                    ones_q     <= 4'd0;
                    lap_hold_q <= 1'b0;
                    running_q  <= 1'b0;
                    if (mode_p) begin
                        state_q <= SET_HOUR;
                    end else if (start_p) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end else if (lap_p) begin
                        clear_q <= 1'b1;
                    end
                end
                RUN: begin
                    running_q  <= 1'b1;
                    cnt_q      <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
                    count_en_q <= (cnt_q == CNT_MAX);
                    if (start_p) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end else if (lap_p) begin
`ifdef STOPWATCH_LAP_EN
                        lap_hold_q <= ~lap_hold_q;
`else
                        lap_hold_q <= 1'b0;
`endif
                    end
                end
                PAUSE: begin
                    running_q <= 1'b0;
                    if (mode_p) begin
                        state_q    <= SET_HOUR;
                        cnt_q      <= '0;
                        lap_hold_q <= 1'b0;
                    end else if (start_p) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end else if (lap_p) begin
                        state_q    <= IDLE;
                        clear_q    <= 1'b1;
                        cnt_q      <= '0;
                        lap_hold_q <= 1'b0;
                    end
                end
                SET_HOUR, SET_MIN, SET_SEC: begin
                    cnt_q      <= '0;
                    lap_hold_q <= 1'b0;
                    running_q  <= 1'b0;
                    if (mode_p) begin
                        load_q     <= 1'b1;
                        load_sel_q <= field_sel;
                        tens_q     <= base_tens;
                        ones_q     <= base_ones;
                        state_q    <= field_next;
                    end else if (start_p) begin
                        state_q <= IDLE;
                        tens_q  <= 4'd0;
                        ones_q  <= 4'd0;
                    end else if (inc_p) begin
                        tens_q <= inc_tens;
                        ones_q <= inc_ones;
                    end else begin
                        tens_q <= base_tens;
                        ones_q <= base_ones;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.count_en = count_en_q;
    assign bus.clear    = clear_q;
    assign bus.load     = load_q;
    assign bus.load_sel = load_sel_q;
    assign bus.set_tens = tens_q;
    assign bus.set_ones = ones_q;
    assign bus.lap_hold = lap_hold_q;
    assign bus.running  = running_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed + sparse random button stimulus, checked every
// cycle against a behavioural stopwatch model, plus hand-computed pins.
module tb_stopwatch_ctrl;

    localparam int TICK = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    stopwatch_ctrl_if bus_if ();

    stopwatch_ctrl #(.TICK_DIV(TICK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: mode 0 idle,1 run,2 pause,3 hour,4 min,5 sec; value as a plain integer.
    int m_mode, m_phase, m_val, m_lap, key, shown;
    int e_cen, e_clr, e_load, e_sel, e_tens, e_ones, e_lap, e_run, e_state;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_phase = 0; m_val = 0; m_lap = 0;
            e_cen = 0; e_clr = 0; e_load = 0; e_sel = 0; e_tens = 0; e_ones = 0;
            e_lap = 0; e_run = 0; e_state = 0;
        end else begin
            key = bus_if.btn_mode ? 1 : bus_if.btn_start ? 2 : bus_if.btn_lap ? 3 : bus_if.btn_inc ? 4 : 0;
            e_cen = 0; e_clr = 0; e_load = 0; e_sel = 0; shown = -1;
            case (m_mode)
                0: begin
                    if (key == 1) begin m_mode = 3; m_val = 0; end
                    else if (key == 2) m_mode = 1;
                    else if (key == 3) e_clr = 1;
                end
                1: begin
                    m_phase = m_phase + 1;
                    if (m_phase == TICK) begin e_cen = 1; m_phase = 0; end
                    if (key == 2) m_mode = 2;
                    else if (key == 3) begin
`ifdef STOPWATCH_LAP_EN
                        m_lap = 1 - m_lap;
`endif
                    end
                end
                2: begin
                    if (key == 1) begin m_mode = 3; m_val = 0; end
                    else if (key == 2) m_mode = 1;
                    else if (key == 3) begin e_clr = 1; m_mode = 0; end
                end
                default: begin
                    if (key == 1) begin
                        e_load = 1;
                        e_sel  = 1 << (5 - m_mode);
                        shown  = m_val;
                        m_val  = 0;
                        m_mode = (m_mode == 5) ? 0 : m_mode + 1;
                    end else if (key == 2) m_mode = 0;
                    else if (key == 4) m_val = (m_val + 1) % ((m_mode == 3) ? 24 : 60);
                end
            endcase
            if (m_mode != 1 && m_mode != 2) begin m_lap = 0; m_phase = 0; end
            if (shown < 0) shown = (m_mode >= 3) ? m_val : 0;
            e_tens = shown / 10; e_ones = shown % 10;
            e_lap = m_lap; e_state = m_mode; e_run = (m_mode == 1) ? 1 : 0;
        end
    end

    // Compare DUT against the model every cycle, clear of the edge.
    always @(posedge clk) begin
        #3;
        check("count_en", 32'(bus_if.count_en), e_cen);
        check("clear",    32'(bus_if.clear),    e_clr);
        check("load",     32'(bus_if.load),     e_load);
        check("load_sel", 32'(bus_if.load_sel), e_sel);
        check("set_tens", 32'(bus_if.set_tens), e_tens);
        check("set_ones", 32'(bus_if.set_ones), e_ones);
        check("lap_hold", 32'(bus_if.lap_hold), e_lap);
        check("running",  32'(bus_if.running),  e_run);
        check("state",    32'(bus_if.state),    e_state);
    end

    task automatic pulse(input bit m, input bit s, input bit l, input bit i);
        bus_if.btn_mode = m; bus_if.btn_start = s; bus_if.btn_lap = l; bus_if.btn_inc = i;
        @(negedge clk);
        bus_if.btn_mode = 0; bus_if.btn_start = 0; bus_if.btn_lap = 0; bus_if.btn_inc = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic incs(input int n);
        for (int k = 0; k < n; k++) pulse(0, 0, 0, 1);
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1;
        bus_if.btn_mode = 0; bus_if.btn_start = 0; bus_if.btn_lap = 0; bus_if.btn_inc = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("pin_reset_state", 32'(bus_if.state), 0);
        check("pin_reset_running", 32'(bus_if.running), 0);
        check("pin_reset_load_sel", 32'(bus_if.load_sel), 0);

        // Start, first tick TICK cycles later, pause and resume with remaining phase.
        pulse(0, 1, 0, 0);
        check("pin_running_rise", 32'(bus_if.running), 1);
        idle(3);
        check("pin_no_tick_early", 32'(bus_if.count_en), 0);
        idle(1);
        check("pin_first_tick", 32'(bus_if.count_en), 1);
        pulse(0, 1, 0, 0);
        check("pin_pause_state", 32'(bus_if.state), 2);
        idle(5);
        pulse(0, 1, 0, 0);
        idle(2);
        check("pin_resume_no_tick", 32'(bus_if.count_en), 0);
        idle(1);
        check("pin_resume_tick", 32'(bus_if.count_en), 1);

        // Lap in RUN, then clear from PAUSE.
        pulse(0, 0, 1, 0);
`ifdef STOPWATCH_LAP_EN
        check("pin_lap_hold_on", 32'(bus_if.lap_hold), 1);
`else
        check("pin_lap_hold_off", 32'(bus_if.lap_hold), 0);
`endif
        idle(4);
        pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        check("pin_clear_pulse", 32'(bus_if.clear), 1);
        check("pin_clear_idle", 32'(bus_if.state), 0);
        check("pin_clear_lap0", 32'(bus_if.lap_hold), 0);
        idle(1);
        check("pin_clear_single", 32'(bus_if.clear), 0);

        // Set hours with 23->00 wrap, then minutes, abort in seconds.
        pulse(1, 0, 0, 0);
        check("pin_set_hour", 32'(bus_if.state), 3);
        incs(25);
        check("pin_hour_tens", 32'(bus_if.set_tens), 0);
        check("pin_hour_ones", 32'(bus_if.set_ones), 1);
        pulse(1, 0, 0, 0);
        check("pin_hour_load", 32'(bus_if.load), 1);
        check("pin_hour_sel", 32'(bus_if.load_sel), 3'b100);
        check("pin_hour_load_ones", 32'(bus_if.set_ones), 1);
        check("pin_set_min", 32'(bus_if.state), 4);
        idle(1);
        check("pin_min_start_ones", 32'(bus_if.set_ones), 0);
        check("pin_min_sel_idle", 32'(bus_if.load_sel), 0);
        incs(60);
        check("pin_min_wrap_tens", 32'(bus_if.set_tens), 0);
        check("pin_min_wrap_ones", 32'(bus_if.set_ones), 0);
        incs(7);
        check("pin_min_ones7", 32'(bus_if.set_ones), 7);
        pulse(1, 0, 0, 0);
        check("pin_min_sel", 32'(bus_if.load_sel), 3'b010);
        check("pin_min_load_ones", 32'(bus_if.set_ones), 7);
        check("pin_set_sec", 32'(bus_if.state), 5);
        idle(1);
        incs(12);
        check("pin_sec_tens", 32'(bus_if.set_tens), 1);
        check("pin_sec_ones", 32'(bus_if.set_ones), 2);
        pulse(0, 1, 0, 0);
        check("pin_abort_idle", 32'(bus_if.state), 0);
        check("pin_abort_noload", 32'(bus_if.load), 0);

        // Back-to-back mode pulses walk all three loads.
        pulse(1, 0, 0, 0); pulse(1, 0, 0, 0); pulse(1, 0, 0, 0); pulse(1, 0, 0, 0);
        check("pin_b2b_sec_sel", 32'(bus_if.load_sel), 3'b001);
        idle(2);

        // mode+start together in PAUSE enters set mode.
        pulse(0, 1, 0, 0);
        idle(2);
        pulse(0, 1, 0, 0);
        pulse(1, 1, 0, 0);
        check("pin_mode_beats_start", 32'(bus_if.state), 3);
        pulse(0, 1, 0, 0);

        // Reset during a load cycle.
        pulse(1, 0, 0, 0);
        incs(3);
        pulse(1, 0, 0, 0);
        check("pin_pre_reset_load", 32'(bus_if.load), 1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("pin_rst_load", 32'(bus_if.load), 0);
        check("pin_rst_sel", 32'(bus_if.load_sel), 0);
        check("pin_rst_ones", 32'(bus_if.set_ones), 0);
        check("pin_rst_state", 32'(bus_if.state), 0);

        // Sparse random buttons, checked by the model only.
        for (int k = 0; k < 400; k++) begin
            pulse(($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
